regfile_multiport_sb: RTL and testbench

//   Parametrised integer register file for the RV32 datapath: DEPTH x XLEN storage,
//   NUM_RD combinational read ports, one synchronous write port, hardwired-zero x0.

---
 rtl/regfile_multiport_sb_if.sv | 46 ++++
 rtl/regfile_multiport_sb.sv | 94 +++++++++
 tb/tb_regfile_multiport_sb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_sb_if.sv
// Register file bus: read ports for decode, write port for writeback, and the
// scoreboard issue port. The decode/writeback side uses the master modport and the
// register file uses the slave modport.
//
// Handshake: this bus has no valid/ready pair. we and sb_set are single-cycle
// strobes, sampled on every rising clk edge together with their address and data.
// Reads are combinational and always valid, so rd_data and rd_busy follow rd_addr
// within the same cycle.
interface regfile_multiport_sb_if #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   we;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic                   sb_set;
    logic [AW-1:0]          sb_addr;

    modport master (
        output rd_addr,
        input  rd_data,
        input  rd_busy,
        output we,
        output wr_addr,
        output wr_data,
        output sb_set,
        output sb_addr
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        output rd_busy,
        input  we,
        input  wr_addr,
        input  wr_data,
        input  sb_set,
        input  sb_addr
    );
endinterface

// File: rtl/regfile_multiport_sb.sv
// Integer register file with a busy scoreboard for the RV32 datapath.
// DEPTH x XLEN storage, NUM_RD combinational read ports, one synchronous write
// port, and a hardwired-zero x0. A register's busy bit is set when an instruction
// writing it issues, and cleared when its result is written back. Decode uses the
// busy bits to stall on producers that are still in flight.
//
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a write in the
// current cycle is forwarded to any read port with the same address, and that
// port's busy flag reads 0. When it is undefined, reads show stored state only.
//
// There is no FSM. The only state is the register array and the busy vector.
// Both are exposed through the read ports.
module regfile_multiport_sb #(
    parameter int              XLEN          = 32,
    parameter int              DEPTH         = 32,
    parameter int              NUM_RD        = 2,
    parameter int              RESET_REG_IDX = 9,
    parameter logic [XLEN-1:0] RESET_REG_VAL = 32'h00000020
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_multiport_sb_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0]        regs [DEPTH];
    logic [DEPTH-1:0]       busy;
    logic [DEPTH-1:0]       busy_nxt;
    logic                   wr_hit;
    logic                   set_hit;
    logic [NUM_RD*XLEN-1:0] rd_data_c;
    logic [NUM_RD-1:0]      rd_busy_c;

    // Writes and issues that target x0 are treated as no-ops.
    assign wr_hit  = bus.we && (bus.wr_addr != '0);
    assign set_hit = bus.sb_set && (bus.sb_addr != '0);

    // Register array: reset loads the boot value, and writeback stores the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= ((RESET_REG_IDX != 0) && (i == RESET_REG_IDX)) ? RESET_REG_VAL : '0;
            end
        end else if (wr_hit) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Next busy vector. The clear is applied first and the set second, so a new
    // producer issued on the same edge as a writeback to that register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_hit) begin
            busy_nxt[bus.wr_addr] = 1'b0;
        end
        if (set_hit) begin
            busy_nxt[bus.sb_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy scoreboard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read ports. Each port is independent. x0 and the reset-asserted state always
    // read as zero and not busy.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rst && (bus.rd_addr[p*AW +: AW] != '0)) begin
                rd_data_c[p*XLEN +: XLEN] = regs[bus.rd_addr[p*AW +: AW]];
                rd_busy_c[p]              = busy[bus.rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                // Forward the value being written back this cycle. This removes
                // the bubble between writeback and decode.
                if (wr_hit && (bus.wr_addr == bus.rd_addr[p*AW +: AW])) begin
                    rd_data_c[p*XLEN +: XLEN] = bus.wr_data;
                    rd_busy_c[p]              = 1'b0;
                end
`endif
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;
endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Bench for regfile_multiport_sb, configured with DEPTH=16 and NUM_RD=4.
// Driver tasks change inputs 1ns after each rising edge and queue the read-port
// response expected in that cycle. A monitor on the falling edge pops each
// expectation and compares it with the DUT.
module tb_regfile_multiport_sb;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int NUM_RD = 4;
    localparam int AW     = $clog2(DEPTH);
    localparam int EW     = 2 + 1 + XLEN;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    regfile_multiport_sb_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

    regfile_multiport_sb #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD),
        .RESET_REG_IDX(9), .RESET_REG_VAL(32'h00000020)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within 200000 ns");
        $fatal(1, "timeout");
    end

    // Scoreboard. Each entry holds {port[1:0], busy, data}.
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            passes = 0;

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int port, input logic [AW-1:0] addr);
        bus.rd_addr[port*AW +: AW] = addr;
    endtask

    task automatic push_exp(input int port, input logic [XLEN-1:0] d, input logic b, input string nm);
        logic [1:0] pp;
        pp = port[1:0];
        exp_q.push_back({pp, b, d});
        name_q.push_back(nm);
    endtask

    task automatic expect_rd(input int port, input logic [AW-1:0] addr,
                             input logic [XLEN-1:0] d, input logic b, input string nm);
        set_rd(port, addr);
        push_exp(port, d, b, nm);
    endtask

    task automatic drive_wr(input logic w, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.we      = w;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic drive_sb(input logic s, input logic [AW-1:0] a);
        bus.sb_set  = s;
        bus.sb_addr = a;
    endtask

    // Monitor: compares every queued expectation against the stable outputs.
    logic [EW-1:0]   m_e;
    string           m_n;
    int              m_p;
    logic [XLEN-1:0] m_d;
    logic            m_b;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            m_n = name_q.pop_front();
            m_p = int'(m_e[EW-1 -: 2]);
            m_d = bus.rd_data[m_p*XLEN +: XLEN];
            m_b = bus.rd_busy[m_p];
            checks++;
            if (m_d !== m_e[XLEN-1:0] || m_b !== m_e[XLEN]) begin
                $display("FAIL %s: port %0d got data=%h busy=%b, expected data=%h busy=%b",
                         m_n, m_p, m_d, m_b, m_e[XLEN-1:0], m_e[XLEN]);
            end else begin
                passes++;
            end
        end
    end

    // Reference state for the randomised phase.
    logic [XLEN-1:0] m_regs [DEPTH];
    logic [DEPTH-1:0] m_busy;
    logic            r_w, r_s;
    logic [AW-1:0]   r_wa, r_sa, r_ra;
    logic [XLEN-1:0] r_wd, r_ed;
    logic            r_eb;

    initial begin
        rst = 1'b0;
        bus.rd_addr = '0;
        drive_wr(1'b0, '0, '0);
        drive_sb(1'b0, '0);
        tick();

        // 1: Reset. Outputs are forced to zero while reset is held, then the boot value appears.
        expect_rd(0, 4'd9, 32'h0, 1'b0, "rst_held_x9");
        expect_rd(1, 4'd5, 32'h0, 1'b0, "rst_held_x5");
        tick();
        rst = 1'b1;
        expect_rd(0, 4'd9, 32'h00000020, 1'b0, "rst_x9_boot");
        expect_rd(1, 4'd5, 32'h0, 1'b0, "rst_x5_zero");
        expect_rd(2, 4'd0, 32'h0, 1'b0, "rst_x0_zero");
        tick();

        // 2: Write/read, and a write to x0 that must be dropped.
        drive_wr(1'b1, 4'd5, 32'hDEADBEEF);
        tick();
        drive_wr(1'b1, 4'd0, 32'h00001234);
        expect_rd(0, 4'd5, 32'hDEADBEEF, 1'b0, "wr_x5");
        tick();
        drive_wr(1'b0, '0, '0);
        expect_rd(0, 4'd0, 32'h0, 1'b0, "x0_drop_p0");
        expect_rd(1, 4'd0, 32'h0, 1'b0, "x0_drop_p1");
        tick();

        // 3: Scoreboard set, clear on writeback, and set winning over a same-edge clear.
        drive_sb(1'b1, 4'd7);
        tick();
        drive_sb(1'b1, 4'd0);
        drive_wr(1'b1, 4'd7, 32'h000000A5);
        expect_rd(0, 4'd7, BYP ? 32'h000000A5 : 32'h0, BYP ? 1'b0 : 1'b1, "sb_x7_busy");
        tick();
        drive_sb(1'b0, '0);
        drive_wr(1'b0, '0, '0);
        expect_rd(0, 4'd7, 32'h000000A5, 1'b0, "sb_x7_cleared");
        expect_rd(1, 4'd0, 32'h0, 1'b0, "sb_x0_never_busy");
        tick();
        drive_sb(1'b1, 4'd7);
        drive_wr(1'b1, 4'd7, 32'h00000077);
        tick();
        drive_sb(1'b1, 4'd7);
        drive_wr(1'b0, '0, '0);
        expect_rd(0, 4'd7, 32'h00000077, 1'b1, "sb_set_wins");
        tick();
        drive_sb(1'b0, '0);
        drive_wr(1'b1, 4'd7, 32'h00000078);
        expect_rd(0, 4'd7, BYP ? 32'h00000078 : 32'h00000077, BYP ? 1'b0 : 1'b1, "sb_reset_busy");
        tick();
        drive_wr(1'b1, 4'd7, 32'h00000079);
        expect_rd(0, 4'd7, BYP ? 32'h00000079 : 32'h00000078, 1'b0, "sb_single_clear");
        tick();
        drive_wr(1'b0, '0, '0);
        expect_rd(0, 4'd7, 32'h00000079, 1'b0, "sb_clear_nonbusy");
        tick();

        // 4: Same-cycle write and read. Bypass depends on the build; other ports are unaffected.
        drive_wr(1'b1, 4'd3, 32'h00000055);
        expect_rd(1, 4'd3, BYP ? 32'h00000055 : 32'h0, 1'b0, "byp_p1_x3");
        expect_rd(0, 4'd3, BYP ? 32'h00000055 : 32'h0, 1'b0, "byp_p0_x3");
        expect_rd(2, 4'd5, 32'hDEADBEEF, 1'b0, "byp_p2_other");
        tick();
        drive_wr(1'b0, '0, '0);
        expect_rd(1, 4'd3, 32'h00000055, 1'b0, "byp_next_cycle");
        tick();

        // 5: Asynchronous reset dropped in the middle of operation.
        drive_sb(1'b1, 4'd7);
        tick();
        drive_sb(1'b0, '0);
        expect_rd(1, 4'd7, 32'h00000079, 1'b1, "mid_x7_busy");
        tick();
        rst = 1'b0;
        expect_rd(0, 4'd5, 32'h0, 1'b0, "mid_rst_x5");
        expect_rd(1, 4'd7, 32'h0, 1'b0, "mid_rst_x7");
        expect_rd(2, 4'd9, 32'h0, 1'b0, "mid_rst_x9");
        tick();
        rst = 1'b1;
        expect_rd(0, 4'd5, 32'h0, 1'b0, "post_rst_x5");
        expect_rd(1, 4'd7, 32'h0, 1'b0, "post_rst_x7");
        expect_rd(2, 4'd9, 32'h00000020, 1'b0, "post_rst_x9");
        expect_rd(3, 4'd3, 32'h0, 1'b0, "post_rst_x3");
        tick();
        // A write held across a reset edge is lost. The first edge after release performs normally.
        rst = 1'b0;
        drive_wr(1'b1, 4'd5, 32'h00001111);
        drive_sb(1'b1, 4'd5);
        tick();
        rst = 1'b1;
        drive_wr(1'b1, 4'd6, 32'h00000066);
        drive_sb(1'b1, 4'd8);
        expect_rd(0, 4'd5, 32'h0, 1'b0, "rst_edge_write_lost");
        tick();
        drive_wr(1'b0, '0, '0);
        drive_sb(1'b0, '0);
        expect_rd(0, 4'd6, 32'h00000066, 1'b0, "release_write");
        expect_rd(1, 4'd8, 32'h0, 1'b1, "release_set");
        tick();

        // 6: All four ports read the top register.
        drive_wr(1'b1, 4'd15, 32'hFFFFFFFF);
        tick();
        drive_wr(1'b0, '0, '0);
        for (int p = 0; p < NUM_RD; p++) expect_rd(p, 4'd15, 32'hFFFFFFFF, 1'b0, "all_ports_x15");
        tick();

        // Randomised traffic against the reference model, starting from a fresh reset.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        m_regs[9] = 32'h00000020;
        m_busy    = '0;
        for (int c = 0; c < 300; c++) begin
            r_w  = 1'($urandom_range(0, 1));
            r_s  = 1'($urandom_range(0, 1));
            r_wa = AW'($urandom_range(0, DEPTH-1));
            r_sa = AW'($urandom_range(0, DEPTH-1));
            r_wd = $urandom;
            drive_wr(r_w, r_wa, r_wd);
            drive_sb(r_s, r_sa);
            for (int p = 0; p < NUM_RD; p++) begin
                r_ra = AW'($urandom_range(0, DEPTH-1));
                if (r_ra == 0) begin
                    r_ed = '0;
                    r_eb = 1'b0;
                end else if (BYP && r_w && r_wa == r_ra) begin
                    r_ed = r_wd;
                    r_eb = 1'b0;
                end else begin
                    r_ed = m_regs[r_ra];
                    r_eb = m_busy[r_ra];
                end
                expect_rd(p, r_ra, r_ed, r_eb, "random");
            end
            tick();
            if (r_w && r_wa != 0) begin
                m_regs[r_wa] = r_wd;
                m_busy[r_wa] = 1'b0;
            end
            if (r_s && r_sa != 0) m_busy[r_sa] = 1'b1;
        end
        drive_wr(1'b0, '0, '0);
        drive_sb(1'b0, '0);
        tick();
        tick();

        // Final report.
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end else begin
            passes++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
